// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator: state encoding and default widths.
package prod_accum_pkg;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum_dp.sv
// Accumulator datapath: sum register, zero-extending adder with carry-out,
// sticky overflow flag and the remaining-products down-counter.
module prod_accum_dp #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              acc_en,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic [CNT_W-1:0]  cnt,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // One extra bit on the adder carries the wrap-out into the sticky flag.
  logic [ACC_W:0] add_res;
  assign add_res = {1'b0, sum} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (clr) begin
      sum      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      sum      <= '0;
      cnt      <= len;
      overflow <= 1'b0;
    end else if (acc_en) begin
      sum      <= add_res[ACC_W-1:0];
      cnt      <= cnt - CNT_ONE;
      overflow <= overflow | add_res[ACC_W];
    end
  end

endmodule

// File: rtl/prod_accum.sv
// Product accumulator top: run-control FSM, valid/ready decode and done/busy generation.
// Handshake: a product transfers on a rising edge where prod_valid && prod_ready;
// prod_ready depends on state only, and prod_valid may drop at any time.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              done,
  output logic              busy,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic              load, acc_en;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (len != '0) ? ACC : DONE;
        end
      end
      ACC: begin
        if (prod_valid) begin
          acc_en = 1'b1;
          if (cnt == CNT_ONE) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign prod_ready = (state_q == ACC);
  assign done       = (state_q == DONE);
  assign busy       = (state_q == ACC) || (state_q == DONE);
  assign dbg_state  = state_q;

  // Reset drives the datapath clear so it outranks load and accumulate.
  prod_accum_dp #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) u_dp (
    .clk      (Clk),
    .clr      (Reset),
    .load     (load),
    .acc_en   (acc_en),
    .len      (len),
    .prod     (prod),
    .sum      (sum),
    .cnt      (cnt),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: a 16-bit and a 9-bit accumulator driven in lockstep and
// checked every cycle against a run-level model (true total, remaining count).
module tb_prod_accum;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [3:0] len;
  logic       prod_valid;
  logic [7:0] prod;

  logic        ready16, done16, busy16, ovf16;
  logic [15:0] sum16;
  logic [1:0]  st16;
  logic        ready9, done9, busy9, ovf9;
  logic [8:0]  sum9;
  logic [1:0]  st9;

  int checks = 0;
  int errors = 0;

  // Model: true (unwrapped) total of accepted products, and run progress.
  int m_total     = 0;
  int m_remaining = 0;
  bit m_running   = 1'b0;
  bit m_done      = 1'b0;
  int m_xfers     = 0;

  logic [31:0] exp_q[$];

  always #5 Clk = ~Clk;

  prod_accum dut16 (
    .Clk(Clk), .Reset(Reset), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(ready16),
    .sum(sum16), .done(done16), .busy(busy16), .overflow(ovf16),
    .dbg_state(st16)
  );

  prod_accum #(.ACC_W(9)) dut9 (
    .Clk(Clk), .Reset(Reset), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(ready9),
    .sum(sum9), .done(done9), .busy(busy9), .overflow(ovf9),
    .dbg_state(st9)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] exp_st;
    exp_st = m_running ? 2'd1 : (m_done ? 2'd2 : 2'd0);
    check("ready16", {31'b0, ready16}, {31'b0, m_running});
    check("busy16",  {31'b0, busy16},  {31'b0, m_running | m_done});
    check("done16",  {31'b0, done16},  {31'b0, m_done});
    check("sum16",   {16'b0, sum16},   m_total % 65536);
    check("ovf16",   {31'b0, ovf16},   (m_total >= 65536) ? 32'd1 : 32'd0);
    check("state16", {30'b0, st16},    {30'b0, exp_st});
    check("ready9",  {31'b0, ready9},  {31'b0, m_running});
    check("done9",   {31'b0, done9},   {31'b0, m_done});
    check("sum9",    {23'b0, sum9},    m_total % 512);
    check("ovf9",    {31'b0, ovf9},    (m_total >= 512) ? 32'd1 : 32'd0);
  endtask

  // Advance the model by one edge using the inputs now applied, clock, then check.
  task automatic step();
    if (Reset) begin
      m_running = 1'b0; m_done = 1'b0; m_total = 0; m_remaining = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_running) begin
      if (prod_valid) begin
        m_total += int'(prod);
        m_remaining--;
        m_xfers++;
        if (m_remaining == 0) begin
          m_running = 1'b0;
          m_done    = 1'b1;
        end
      end
    end else if (start) begin
      m_total     = 0;
      m_remaining = int'(len);
      m_xfers     = 0;
      if (len == 4'd0) m_done = 1'b1;
      else             m_running = 1'b1;
    end
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1'b1; len = l;
    step();
    start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0;
    step(); step();
    Reset = 1'b0;
    step();

    // Three back-to-back products of 143.
    prod = 8'd143; prod_valid = 1'b1;
    do_start(4'd3);
    step(); step(); step();
    check("t1_done", {31'b0, done16}, 32'd1);
    check("t1_sum", {16'b0, sum16}, 32'd429);
    check("t1_xfers", m_xfers, 32'd3);
    step();
    check("t1_ready_after", {31'b0, ready16}, 32'd0);
    prod_valid = 1'b0;
    step();

    // Zero-length run.
    prod_valid = 1'b1;
    do_start(4'd0);
    check("t2_done", {31'b0, done16}, 32'd1);
    check("t2_sum", {16'b0, sum16}, 32'd0);
    step();
    prod_valid = 1'b0;

    // Wrap in the 9-bit instance.
    prod_valid = 1'b1;
    do_start(4'd3);
    prod = 8'd255; step(); step();
    prod = 8'd10;  step();
    check("t3_sum9", {23'b0, sum9}, 32'd8);
    check("t3_ovf9", {31'b0, ovf9}, 32'd1);
    check("t3_sum16", {16'b0, sum16}, 32'd520);
    prod_valid = 1'b0;
    step();
    do_start(4'd1);
    check("t3_ovf_cleared", {31'b0, ovf9}, 32'd0);
    prod = 8'd1; prod_valid = 1'b1;
    step(); step();
    prod_valid = 1'b0;

    // Gappy valid: 1,0,0,1,1,0,1 with four products of 10.
    prod = 8'd10;
    do_start(4'd4);
    exp_q = '{1, 0, 0, 1, 1, 0, 1};
    foreach (exp_q[i]) begin
      prod_valid = exp_q[i][0];
      step();
    end
    check("t4_sum", {16'b0, sum16}, 32'd40);
    check("t4_xfers", m_xfers, 32'd4);
    prod_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      prod_valid = i[0]; prod = 8'(i * 37 + 5);
      step();
    end
    check("t4_idle_sum", {16'b0, sum16}, 32'd40);
    prod_valid = 1'b0;

    // Reset mid-run after two transfers of 50.
    prod = 8'd50; prod_valid = 1'b1;
    do_start(4'd4);
    step(); step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t5_sum", {16'b0, sum16}, 32'd0);
    check("t5_busy", {31'b0, busy16}, 32'd0);
    check("t5_done", {31'b0, done16}, 32'd0);
    prod = 8'd7;
    do_start(4'd1);
    step();
    check("t5_done7", {31'b0, done16}, 32'd1);
    check("t5_sum7", {16'b0, sum16}, 32'd7);
    step();

    // start with len=9 during ACC and DONE must be ignored.
    prod = 8'd21; prod_valid = 1'b0;
    do_start(4'd2);
    start = 1'b1; len = 4'd9;
    step();
    prod_valid = 1'b1;
    step(); step();
    check("t6_done", {31'b0, done16}, 32'd1);
    check("t6_sum", {16'b0, sum16}, 32'd42);
    start = 1'b0; prod_valid = 1'b0;
    step();
    check("t6_idle", {31'b0, busy16}, 32'd0);

    // Random runs.
    for (int r = 0; r < 25; r++) begin
      int budget;
      prod = 8'($urandom_range(0, 255));
      prod_valid = 1'($urandom_range(0, 1));
      do_start(4'($urandom_range(0, 15)));
      budget = 0;
      while ((m_running || m_done) && budget < 300) begin
        prod = 8'($urandom_range(0, 255));
        prod_valid = (budget > 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
        start = 1'($urandom_range(0, 1));
        len = 4'($urandom_range(0, 15));
        step();
        budget++;
      end
      start = 1'b0;
      checks++;
      if (budget >= 300) begin
        errors++;
        $error("FAIL rand_timeout: observed %0d cycles expected under 300", budget);
      end
      prod_valid = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
# prod_accum

Downstream accumulator for the 4-bit sequential multiplier. It consumes a programmed number of 8-bit products over a valid/ready handshake and sums them into a wider register. When the last product is accepted it raises a one-cycle `done` and holds the final sum. Together with the multiplier it forms a small dot-product / MAC unit.

## Interface
- `PROD_W`, 8, product width; matches the multiplier's `Prod`.
- `ACC_W`, 16, accumulator width; must be ≥ `PROD_W`.
- `CNT_W`, 4, width of the length field; up to 2^CNT_W−1 products per run.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `start` input 1: begin a new run. Honoured only in IDLE.
- `len` input CNT_W: number of products in the run. Sampled with `start`.
- `prod_valid` input 1: upstream has a product on `prod`.
- `prod` input PROD_W: unsigned product.
- `prod_ready` output 1: high in ACC state only. A transfer occurs on a rising edge where `prod_valid && prod_ready`.
- `sum` output ACC_W: running / final sum. Held from DONE until the next accepted `start`.
- `done` output 1: one-cycle pulse; `sum` is final in that cycle.
- `busy` output 1: high in ACC and DONE.
- `overflow` output 1: sticky carry-out of the accumulator; cleared by `start` or `Reset`.

## Operation
- States: IDLE, ACC, DONE.
- IDLE, with `start`=1:
  - `sum`←0, `overflow`←0, `cnt`←`len`.
  - Next state is ACC if `len`≠0, else DONE.
- IDLE, with `start`=0: stay in IDLE; `prod_valid` is ignored.
- ACC, on each transfer:
  - `{carry,sum}` ← `sum` + zero-extended `prod`. The sum wraps modulo 2^ACC_W; `carry` ORs into `overflow`.
  - `cnt`←`cnt`−1.
  - On the transfer with `cnt`==1, next state is DONE.
  - `start` is ignored in ACC.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `start` is ignored in DONE.
- Reset:
  - State IDLE; `sum`=0, `cnt`=0, `overflow`=0, `done`=0, `busy`=0, `prod_ready`=0.
  - Reset has priority over `start` and over any transfer.
  - Reset mid-run discards the partial sum; no `done` is produced.
- `prod_valid` may drop at any time; the block simply waits. No timeout.

## Timing
- `start` sampled at edge k → `prod_ready`=1 and `busy`=1 from k+1.
- The first product can be accepted at edge k+1.
- Throughput: one product per cycle when `prod_valid` is held high.
- Last transfer at edge m → `done`=1 during cycle m+1 (in DONE), with `sum` final.
  - `prod_ready`=0 from m+1.
  - IDLE and `busy`=0 at m+2.
- `len`=0: `start` at edge k → `done`=1 in cycle k+1 with `sum`=0, IDLE at k+2.
- Minimum run (`len`=1, `prod_valid` held high): start edge k, transfer at k+1, `done` at k+2.
- `sum` changes only on transfer edges or on an accepted `start`. It is stable in IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package `prod_accum_pkg`:
  - state encoding constants: IDLE=2'd0, ACC=2'd1, DONE=2'd2;
  - default widths `PROD_W`/`ACC_W`/`CNT_W`.
- Sub-module `prod_accum_dp`:
  - datapath only: sum register, zero-extend adder with carry-out, sticky overflow, down-counter;
  - controlled by `clr`/`load`/`acc_en` strobes from the FSM in the top.
- Top `prod_accum`: FSM, handshake decode, `done`/`busy` generation.

## Test plan
- `len`=3, `prod` 143,143,143 (13×11) with `prod_valid` held high.
  - Required: three transfers on consecutive edges; `done` pulses once with `sum`=429, `overflow`=0.
  - Required: `prod_ready` low the cycle after `done`.
- `len`=0.
  - Required: `done` the cycle after `start`; `sum`=0; `prod_ready` never high.
- `ACC_W`=9, `len`=3, `prod` 255,255,10.
  - Required: final `sum`=8 (520 mod 512), `overflow`=1.
  - Required: the next `start` clears `overflow` to 0.
- `len`=4, `prod_valid` toggled 1,0,0,1,1,0,1 with `prod`=10 on valid cycles.
  - Required: only four transfers counted; `sum`=40.
  - Required: `prod_valid` pulses while in IDLE leave `sum` unchanged.
- `len`=4, `Reset` asserted after 2 transfers of 50.
  - Required: next cycle shows `sum`=0, IDLE, `busy`=0, no `done`.
  - Required: a fresh `start` with `len`=1, `prod`=7 gives `done` with `sum`=7.
- `start` with `len`=9 re-asserted during ACC and during DONE.
  - Required: both ignored; the run completes after the original 2 products (`len`=2), and `len` is not reloaded.
